// File: rtl/trap_arbiter.sv
// Trap-request arbiter: picks the oldest exception or the highest-priority eligible
// interrupt, resolves M/S delegation, and presents the trap on a valid/ready handshake.
module trap_arbiter #(
  parameter int CODE_WIDTH      = 4,
  parameter int INT_COUNT       = 12,
  parameter int EXC_SOURCES     = 2,
  parameter int XLEN            = 32,
  parameter int BLACKOUT_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INT_COUNT-1:0]              int_pending,
  input  logic [INT_COUNT-1:0]              int_enable,
  input  logic [INT_COUNT-1:0]              mideleg,
  input  logic [(2**CODE_WIDTH)-1:0]        medeleg,
  input  logic                              status_mie,
  input  logic                              status_sie,
  input  logic [1:0]                        priv,
  input  logic [EXC_SOURCES-1:0]            exc_valid,
  input  logic [EXC_SOURCES*CODE_WIDTH-1:0] exc_code,
  input  logic [EXC_SOURCES*XLEN-1:0]       exc_tval,
  output logic                              trap_valid,
  input  logic                              trap_ready,
  output logic                              trap_interrupt,
  output logic [CODE_WIDTH-1:0]             trap_code,
  output logic [XLEN-1:0]                   trap_tval,
  output logic [1:0]                        trap_priv,
  output logic                              busy
);
  // Handshake: a trap transfers on a cycle where trap_valid && trap_ready. While
  // trap_valid is high the payload is frozen; trap_ready with trap_valid low is ignored.

  localparam int NCODES = 2**CODE_WIDTH;
  localparam int CNT_W  = (BLACKOUT_CYCLES > 0) ? $clog2(BLACKOUT_CYCLES + 1) : 1;
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state_q, state_d;
  logic [INT_COUNT-1:0]  pend_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  capture, accept;

  // Smaller rank wins. Standard causes first, then codes >= 12 (high first),
  // then the reserved 2/6/10 (high first).
  function automatic int int_rank(input int k);
    case (k)
      11: return 0;
      3:  return 1;
      7:  return 2;
      9:  return 3;
      1:  return 4;
      5:  return 5;
      8:  return 6;
      0:  return 7;
      4:  return 8;
      default: begin
        if (k >= 12) return 9 + (NCODES - 1 - k);
        return 2 * NCODES - k;
      end
    endcase
  endfunction

  logic [INT_COUNT-1:0]  int_elig;
  logic                  int_found;
  logic [CODE_WIDTH-1:0] int_code;
  logic                  int_to_s;

  always_comb begin
    for (int k = 0; k < INT_COUNT; k++) begin
      if (mideleg[k])
        int_elig[k] = pend_q[k] && ((priv == PRIV_U) || ((priv == PRIV_S) && status_sie));
      else
        int_elig[k] = pend_q[k] && ((priv != PRIV_M) || status_mie);
    end
  end

  always_comb begin
    int best;
    best      = 2 ** 30;
    int_found = 1'b0;
    int_code  = '0;
    int_to_s  = 1'b0;
    for (int k = 0; k < INT_COUNT; k++) begin
      if (int_elig[k] && (int_rank(k) < best)) begin
        best      = int_rank(k);
        int_found = 1'b1;
        int_code  = CODE_WIDTH'(k);
        int_to_s  = mideleg[k];
      end
    end
  end

  logic                  exc_found;
  logic [CODE_WIDTH-1:0] exc_sel_code;
  logic [XLEN-1:0]       exc_sel_tval;
  logic                  exc_to_s;

  // Walk from youngest to oldest so the lowest-index valid channel lands last.
  always_comb begin
    exc_found    = 1'b0;
    exc_sel_code = '0;
    exc_sel_tval = '0;
    for (int i = EXC_SOURCES - 1; i >= 0; i--) begin
      if (exc_valid[i]) begin
        exc_found    = 1'b1;
        exc_sel_code = exc_code[i*CODE_WIDTH +: CODE_WIDTH];
        exc_sel_tval = exc_tval[i*XLEN +: XLEN];
      end
    end
    exc_to_s = medeleg[exc_sel_code] && (priv != PRIV_M);
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_found || (int_found && (cnt_q == '0))) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (trap_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pend_q         <= '0;
      cnt_q          <= '0;
      trap_interrupt <= 1'b0;
      trap_code      <= '0;
      trap_tval      <= '0;
      trap_priv      <= PRIV_M;
    end else begin
      state_q <= state_d;
      pend_q  <= int_pending & int_enable;
      if (accept)
        cnt_q <= CNT_W'(BLACKOUT_CYCLES);
      else if (cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      if (capture) begin
        trap_interrupt <= !exc_found;
        trap_code      <= exc_found ? exc_sel_code : int_code;
        trap_tval      <= exc_found ? exc_sel_tval : '0;
        if (exc_found)
          trap_priv <= exc_to_s ? PRIV_S : PRIV_M;
        else
          trap_priv <= int_to_s ? PRIV_S : PRIV_M;
      end
    end
  end

  assign trap_valid = (state_q == HOLD);
  assign busy       = (state_q == HOLD);

endmodule

// File: tb/tb_trap_arbiter.sv
// Bench for trap_arbiter: directed steps followed by random traffic, checked every
// cycle against a cycle-level reference model built from the trap selection rules.
module tb_trap_arbiter;
  localparam int CW  = 4;
  localparam int IC  = 12;
  localparam int ES  = 2;
  localparam int XL  = 32;
  localparam int BC  = 2;
  localparam int PW  = 1 + CW + XL + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [IC-1:0]  int_pending, int_enable, mideleg;
  logic [15:0]    medeleg;
  logic           status_mie, status_sie;
  logic [1:0]     priv;
  logic [ES-1:0]  exc_valid;
  logic [ES*CW-1:0] exc_code;
  logic [ES*XL-1:0] exc_tval;
  logic           trap_valid, trap_ready, trap_interrupt;
  logic [CW-1:0]  trap_code;
  logic [XL-1:0]  trap_tval;
  logic [1:0]     trap_priv;
  logic           busy;

  trap_arbiter #(
    .CODE_WIDTH(CW), .INT_COUNT(IC), .EXC_SOURCES(ES), .XLEN(XL), .BLACKOUT_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .int_pending(int_pending), .int_enable(int_enable),
    .mideleg(mideleg), .medeleg(medeleg), .status_mie(status_mie), .status_sie(status_sie),
    .priv(priv), .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
    .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_interrupt(trap_interrupt),
    .trap_code(trap_code), .trap_tval(trap_tval), .trap_priv(trap_priv), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            passed = 0;
  int            total  = 0;
  int            order[$];
  logic [PW-1:0] exp_q[$];
  bit            m_valid;
  logic [IC-1:0] m_pend;
  int            m_accept;
  int            cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pend   = '0;
    m_accept = -1000;
    exp_q.delete();
  endtask

  task automatic ref_exc(output bit found, output logic [CW-1:0] code, output logic [XL-1:0] tval);
    found = 1'b0; code = '0; tval = '0;
    for (int i = 0; i < ES; i++) begin
      if (exc_valid[i] && !found) begin
        found = 1'b1;
        code  = exc_code[i*CW +: CW];
        tval  = exc_tval[i*XL +: XL];
      end
    end
  endtask

  task automatic ref_int(output bit found, output int code, output logic [1:0] tp);
    found = 1'b0; code = 0; tp = 2'b11;
    foreach (order[i]) begin
      int k;
      bit ok;
      k = order[i];
      if (!found && m_pend[k]) begin
        if (mideleg[k]) ok = (priv == 2'b00) || (priv == 2'b01 && status_sie);
        else            ok = (priv != 2'b11) || status_mie;
        if (ok) begin
          found = 1'b1;
          code  = k;
          tp    = mideleg[k] ? 2'b01 : 2'b11;
        end
      end
    end
  endtask

  // Advance the model by one cycle with the current inputs, clock the DUT, compare.
  task automatic tick();
    bit ef, fi;
    logic [CW-1:0] ec;
    logic [XL-1:0] et;
    int ic;
    logic [1:0] tp;
    if (m_valid) begin
      if (trap_ready) begin
        m_valid = 1'b0;
        void'(exp_q.pop_front());
        m_accept = cyc;
      end
    end else begin
      ref_exc(ef, ec, et);
      if (ef) begin
        exp_q.push_back({1'b0, ec, et, (medeleg[ec] && priv != 2'b11) ? 2'b01 : 2'b11});
        m_valid = 1'b1;
      end else if (cyc - m_accept > BC) begin
        ref_int(fi, ic, tp);
        if (fi) begin
          exp_q.push_back({1'b1, CW'(ic), {XL{1'b0}}, tp});
          m_valid = 1'b1;
        end
      end
    end
    m_pend = int_pending & int_enable;
    cyc++;
    @(posedge clk);
    #1;
    check("trap_valid", 64'(trap_valid), 64'(m_valid));
    check("busy", 64'(busy), 64'(m_valid));
    if (m_valid)
      check("payload", 64'({trap_interrupt, trap_code, trap_tval, trap_priv}), 64'(exp_q[0]));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 8 && !trap_valid; i++) tick();
    check(tag, 64'(trap_valid), 64'd1);
  endtask

  initial begin
    foreach (order[i]) order.delete(i);
    order = '{11, 3, 7, 9, 1, 5, 8, 0, 4};
    for (int k = 15; k >= 12; k--) if (k < IC) order.push_back(k);
    order.push_back(10); order.push_back(6); order.push_back(2);
    cyc = 0;
    model_reset();

    rst = 1'b1; trap_ready = 1'b0;
    int_pending = '0; int_enable = '0; mideleg = '0; medeleg = '0;
    status_mie = 1'b0; status_sie = 1'b0; priv = 2'b11;
    exc_valid = '0; exc_code = '0; exc_tval = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(trap_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_priv", 64'(trap_priv), 64'd3);
    check("rst_code", 64'(trap_code), 64'd0);
    check("rst_tval", 64'(trap_tval), 64'd0);
    check("rst_int", 64'(trap_interrupt), 64'd0);
    rst = 1'b0;

    // Oldest exception wins; delegation depends on medeleg
    priv = 2'b00; exc_valid = 2'b11;
    exc_code = {4'd13, 4'd2}; exc_tval = {32'hdead_beef, 32'h0000_1234};
    tick();
    check("exc_code", 64'(trap_code), 64'd2);
    check("exc_tval", 64'(trap_tval), 64'h1234);
    check("exc_priv_m", 64'(trap_priv), 64'd3);
    check("exc_is_int", 64'(trap_interrupt), 64'd0);
    trap_ready = 1'b1; exc_valid = '0;
    tick();
    trap_ready = 1'b0; medeleg = 16'h0004; exc_valid = 2'b11;
    tick();
    check("exc_priv_s", 64'(trap_priv), 64'd1);
    trap_ready = 1'b1; exc_valid = '0;
    tick();
    trap_ready = 1'b0;
    repeat (2) tick();

    // Interrupt priority and delegation gating
    priv = 2'b01; status_sie = 1'b0;
    int_pending = 12'h8A0; int_enable = 12'h8A0; mideleg = 12'h020;
    tick();
    check("int_lat1", 64'(trap_valid), 64'd0);
    tick();
    check("int_lat2", 64'(trap_valid), 64'd1);
    check("int_mei", 64'(trap_code), 64'd11);
    check("int_mei_priv", 64'(trap_priv), 64'd3);
    check("int_mei_flag", 64'(trap_interrupt), 64'd1);
    trap_ready = 1'b1; int_enable = 12'h0A0;
    tick();
    trap_ready = 1'b0;
    wait_valid("int_mti_seen");
    check("int_mti", 64'(trap_code), 64'd7);
    trap_ready = 1'b1; int_enable = 12'h020;
    tick();
    trap_ready = 1'b0;
    repeat (6) tick();
    check("int_sti_gated", 64'(trap_valid), 64'd0);

    // Exception beats an eligible interrupt in the same cycle
    priv = 2'b11; status_mie = 1'b0; mideleg = '0;
    int_pending = 12'h800; int_enable = 12'h800;
    repeat (3) tick();
    status_mie = 1'b1; exc_valid = 2'b01; exc_code = {4'd0, 4'd8}; exc_tval = {32'h0, 32'h0000_0abc};
    tick();
    check("beat_code", 64'(trap_code), 64'd8);
    check("beat_int", 64'(trap_interrupt), 64'd0);

    // Payload held while not ready, even as the interrupt drops
    int_pending = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_code", 64'(trap_code), 64'd8);
    end
    trap_ready = 1'b1; exc_valid = '0;
    tick();
    check("hold_release", 64'(trap_valid), 64'd0);
    trap_ready = 1'b0;

    // Blackout window after accept
    int_pending = 12'h080; int_enable = 12'h080;
    wait_valid("bo_first");
    check("bo_first_code", 64'(trap_code), 64'd7);
    trap_ready = 1'b1;
    tick();
    trap_ready = 1'b0;
    tick();
    check("bo_gap1", 64'(trap_valid), 64'd0);
    tick();
    check("bo_gap2", 64'(trap_valid), 64'd0);
    tick();
    check("bo_retrap", 64'(trap_valid), 64'd1);
    check("bo_retrap_code", 64'(trap_code), 64'd7);
    trap_ready = 1'b1;
    tick();
    trap_ready = 1'b0; exc_valid = 2'b01; exc_code = {4'd0, 4'd5};
    tick();
    check("bo_exc", 64'(trap_valid), 64'd1);
    check("bo_exc_code", 64'(trap_code), 64'd5);
    trap_ready = 1'b1; exc_valid = '0; int_pending = '0;
    tick();
    trap_ready = 1'b0;

    // Random traffic
    medeleg = 16'($urandom);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) int_pending = IC'($urandom);
      if ($urandom_range(0, 7) == 0) int_enable = IC'($urandom);
      if ($urandom_range(0, 7) == 0) mideleg = IC'($urandom);
      if ($urandom_range(0, 15) == 0) medeleg = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: priv = 2'b00;
          1: priv = 2'b01;
          default: priv = 2'b11;
        endcase
        status_mie = 1'($urandom);
        status_sie = 1'($urandom);
      end
      if (!trap_valid) begin
        exc_valid = ($urandom_range(0, 3) == 0) ? ES'($urandom) : '0;
        exc_code  = (ES*CW)'($urandom);
        exc_tval  = {32'($urandom), 32'($urandom)};
      end
      trap_ready = 1'($urandom);
      tick();
    end

    // Reset while a trap is held
    trap_ready = 1'b0; int_pending = '0;
    exc_valid = 2'b01; exc_code = {4'd0, 4'd6};
    tick();
    if (!trap_valid) tick();
    check("pre_rst_hold", 64'(trap_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(trap_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_priv", 64'(trap_priv), 64'd3);
    exc_valid = '0; int_enable = '0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", 64'(trap_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trap_arbiter.md
Name: trap_arbiter

Overview:
- Parametrised trap-request arbiter between the pipeline's exception sources, the interrupt lines and the CSR/redirect logic.
- Each cycle it selects at most one trap: the oldest exception, or else the highest-priority enabled interrupt.
- It resolves M/S delegation and privilege gating, then presents cause, tval and target privilege on a valid/ready handshake.
- A post-accept blackout window keeps a second interrupt from being taken before the pipeline has redirected.

Parameters:
- CODE_WIDTH, 4, cause code width; delegation masks are 2**CODE_WIDTH bits.
- INT_COUNT, 12, number of interrupt lines (codes 0..INT_COUNT-1); must be <= 2**CODE_WIDTH.
- EXC_SOURCES, 2, number of exception channels; index 0 is the oldest instruction.
- XLEN, 32, tval width.
- BLACKOUT_CYCLES, 2, cycles after an accepted trap during which interrupts are suppressed; 0 disables the window.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- int_pending  in  INT_COUNT  level interrupt lines (mip)
- int_enable  in  INT_COUNT  mie
- mideleg  in  INT_COUNT  interrupt delegation to S
- medeleg  in  2**CODE_WIDTH  exception delegation to S
- status_mie  in  1  mstatus.MIE
- status_sie  in  1  mstatus.SIE
- priv  in  2  current privilege (00 U, 01 S, 11 M)
- exc_valid  in  EXC_SOURCES  per-channel exception request
- exc_code  in  EXC_SOURCES*CODE_WIDTH  per-channel code; channel i at [i*CODE_WIDTH +: CODE_WIDTH]
- exc_tval  in  EXC_SOURCES*XLEN  per-channel tval
- trap_valid  out  1  trap presented
- trap_ready  in  1  consumer accepts trap
- trap_interrupt  out  1  1 = interrupt, 0 = exception
- trap_code  out  CODE_WIDTH  cause code
- trap_tval  out  XLEN  tval; 0 for interrupts
- trap_priv  out  2  target privilege (01 S or 11 M)
- busy  out  1  arbiter not accepting new exceptions

Behaviour:
- Reset (async, immediate): state IDLE, trap_valid=0, trap_interrupt=0, trap_code=0, trap_tval=0, trap_priv=11, busy=0, blackout counter=0, int_pending register=0.
- int_pending & int_enable is registered once (pend_q). Exceptions are combinational into the selector.
- Interrupt eligibility for code k:
  - Not delegated (mideleg[k]=0): target M; eligible if priv!=M, or priv==M and status_mie.
  - Delegated: target S; eligible if priv==U, or priv==S and status_sie; never eligible when priv==M.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5) > UEI(8) > USI(0) > UTI(4). Codes >=12 rank below these, higher code first. Codes 2, 6, 10 rank lowest, in descending code order.
- Exception selection: lowest-index channel with exc_valid=1. Target S if medeleg[code]=1 and priv!=M, else M.
- Exceptions always beat interrupts in the same cycle.
- States:
  - IDLE: if an exception is valid, or an interrupt is eligible and the blackout counter is 0, capture payload into output registers; next state HOLD, trap_valid=1 in the next cycle.
  - HOLD: trap_valid=1, outputs frozen, busy=1. New exc_valid and interrupt changes are ignored; upstream must hold exc_valid while busy. On trap_ready=1, go to IDLE next cycle with trap_valid=0 and load the counter with BLACKOUT_CYCLES.
  - Counter: decrements each cycle while nonzero (any state). While nonzero, interrupts are ineligible; exceptions are still accepted in IDLE.
- Latency:
  - exc_valid at cycle N -> trap_valid at N+1.
  - int_pending at N -> pend_q at N+1 -> trap_valid at N+2.
- Interrupt deasserts while in HOLD: the presented trap is still delivered; no retraction.
- trap_ready while trap_valid=0 has no effect.
- Back-to-back: acceptance in cycle N allows a new capture in cycle N+1 (exceptions only, if BLACKOUT_CYCLES>0), giving trap_valid again at N+2.
- busy=1 in HOLD only.
- rst asserted mid-HOLD: trap is dropped, all state returns to reset values.

Test Plan:
- Reset: rst pulsed high during HOLD -> trap_valid=0, busy=0, trap_priv=11 immediately; no trap for 3 cycles with inputs idle.
- Exception priority: priv=00; exc_valid=11; ch0 code=2, tval=0x0000_1234; ch1 code=13; medeleg=0 -> trap_valid at +1, trap_interrupt=0, trap_code=2, trap_tval=0x1234, trap_priv=11. Repeat with medeleg[2]=1 -> trap_priv=01.
- Interrupt priority: priv=01, status_sie=0, int_pending=int_enable=0x8A0 (codes 5, 7, 11), mideleg=0x020 -> trap at +2 with trap_code=11, trap_priv=11. Mask bit 11 -> trap_code=7. Mask 7 too -> no trap (code 5 delegated, SIE=0).
- Exception beats interrupt: MEI eligible and ch0 code=8 in the same cycle -> trap_code=8, trap_interrupt=0.
- Handshake hold: trap_ready=0 for 4 cycles while int_pending drops -> payload stable, busy=1 all 4 cycles. trap_ready=1 -> trap_valid=0 next cycle.
- Blackout: BLACKOUT_CYCLES=2, MTI still pending after accept -> no interrupt trap for 2 cycles, retrapped at accept+3. An exception arriving at accept+1 -> trap_valid at accept+2.
